// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - serial stream, config and match-event bundle for seq_detect_param
interface seq_detect_param_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in;
    logic             cfg_load;
    logic [N-1:0]     pattern;
    logic             overlap_en;
    logic             clear_cnt;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;

    modport master (
        output in_valid, in, cfg_load, pattern, overlap_en, clear_cnt,
        input  match, match_cnt, armed
    );

    modport slave (
        input  in_valid, in, cfg_load, pattern, overlap_en, clear_cnt,
        output match, match_cnt, armed
    );
endinterface

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - runtime-configurable N-bit serial pattern detector with saturating hit counter
module seq_detect_param #(
    parameter int           N           = 4,
    parameter int           CNT_W       = 8,
    parameter logic [N-1:0] DEFAULT_PAT = {N{1'b0}},
    parameter logic         DEFAULT_OVL = 1'b1
) (
    input logic              clk,
    input logic              reset_n,
    seq_detect_param_if.slave bus
);
    generate
        if (N < 2 || N > 32) begin : g_bad_n
            $error("seq_detect_param: N must be in 2..32");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("seq_detect_param: CNT_W must be at least 1");
        end
    endgenerate

    localparam int             FW       = $clog2(N + 1);
    localparam logic [FW-1:0]  FILL_MAX = FW'(N);
    localparam logic [FW-1:0]  FILL_ARM = FW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     history_q, history_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [N-1:0]     pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic [N-1:0]     win;
    logic             hit;

    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        ovl_d     = ovl_q;
        match_d   = 1'b0;
        cnt_d     = cnt_q;
        hit       = 1'b0;
        win       = {history_q[N-2:0], bus.in};

        // A config load flushes the window; the bit offered on that edge is dropped.
        if (bus.cfg_load) begin
            pat_d     = bus.pattern;
            ovl_d     = bus.overlap_en;
            history_d = '0;
            fill_d    = '0;
        end else if (bus.in_valid) begin
            history_d = win;
            hit       = (fill_q >= FILL_ARM) && (win == pat_q);
            if (hit && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end

        match_d = hit;

        if (bus.clear_cnt) begin
            cnt_d = '0;
        end else if (hit && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        armed_d = (fill_d == FILL_MAX);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            history_q <= '0;
            fill_q    <= '0;
            pat_q     <= DEFAULT_PAT;
            ovl_q     <= DEFAULT_OVL;
            match_q   <= 1'b0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            ovl_q     <= ovl_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
        end
    end

    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
    assign bus.armed     = armed_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed and randomized checks of seq_detect_param against a bit-list model
module tb_seq_detect_param;
    localparam int N     = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    seq_detect_param_if #(.N(N), .CNT_W(CNT_W)) bus ();

    seq_detect_param #(
        .N(N), .CNT_W(CNT_W), .DEFAULT_PAT(4'b0000), .DEFAULT_OVL(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Reference: the valid bits received since the last flush, newest at the back.
    bit       seq[$];
    bit [3:0] m_pat;
    bit       m_ovl;
    bit       m_match;
    int       m_cnt;
    bit       m_armed;
    int       pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int tail_value();
        int v = 0;
        for (int k = 0; k < N; k++)
            v = v * 2 + int'(seq[seq.size() - N + k]);
        return v;
    endfunction

    task automatic model_step();
        bit hit = 0;
        if (!reset_n) begin
            seq.delete();
            m_pat = 4'b0000; m_ovl = 1'b1;
            m_match = 0; m_cnt = 0; m_armed = 0;
            return;
        end
        if (bus.cfg_load) begin
            m_pat = bus.pattern; m_ovl = bus.overlap_en;
            seq.delete();
        end else if (bus.in_valid) begin
            seq.push_back(bus.in);
            if (seq.size() > N) void'(seq.pop_front());
            if (seq.size() == N && tail_value() == int'(m_pat)) hit = 1;
            if (hit && !m_ovl) seq.delete();
        end
        m_match = hit;
        if (bus.clear_cnt) m_cnt = 0;
        else if (hit && m_cnt < CMAX) m_cnt++;
        m_armed = (seq.size() == N);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("match", bus.match, m_match);
        check("match_cnt", bus.match_cnt, m_cnt);
        check("armed", bus.armed, m_armed);
        if (bus.match === 1'b1) pulses++;
        bus.in_valid  = 0;
        bus.cfg_load  = 0;
        bus.clear_cnt = 0;
        reset_n       = 1;
    endtask

    task automatic send(input bit b);
        bus.in_valid = 1; bus.in = b;
        tick();
    endtask

    task automatic send4(input bit [3:0] v);
        for (int k = 3; k >= 0; k--) send(v[k]);
    endtask

    task automatic cfg(input bit [3:0] p, input bit o);
        bus.cfg_load = 1; bus.pattern = p; bus.overlap_en = o; bus.clear_cnt = 1;
        tick();
    endtask

    initial begin
        bus.in_valid = 0; bus.in = 0; bus.cfg_load = 0;
        bus.pattern = '0; bus.overlap_en = 0; bus.clear_cnt = 0;
        reset_n = 0;
        tick();
        check("reset_match", bus.match, 0);
        check("reset_cnt", bus.match_cnt, 0);
        check("reset_armed", bus.armed, 0);

        // Overlapping: 1011011 hits after bits 4 and 7
        cfg(4'b1011, 1);
        pulses = 0;
        send4(4'b1011); send(0); send(1); send(1);
        check("ovl_pulses", pulses, 2);
        check("ovl_cnt", bus.match_cnt, 2);

        // Non-overlapping: same stream hits once, armed drops after the hit
        cfg(4'b1011, 0);
        pulses = 0;
        send4(4'b1011);
        check("novl_armed_after_hit", bus.armed, 0);
        send(0); send(1); send(1);
        check("novl_pulses", pulses, 1);
        check("novl_cnt", bus.match_cnt, 1);

        // Valid gaps do not disturb the window
        cfg(4'b1011, 1);
        pulses = 0;
        send(1); send(0);
        for (int k = 0; k < 3; k++) begin
            bus.in = k[0];
            tick();
        end
        send(1);
        check("gap_no_early", bus.match, 0);
        send(1);
        check("gap_hit", bus.match, 1);
        check("gap_pulses", pulses, 1);

        // Saturation and clear on the same edge as a hit
        cfg(4'b1111, 1);
        pulses = 0;
        for (int k = 0; k < 8; k++) send(1);
        check("sat_pulses", pulses, 5);
        check("sat_cnt", bus.match_cnt, 3);
        bus.clear_cnt = 1;
        send(1);
        check("clr_match", bus.match, 1);
        check("clr_cnt", bus.match_cnt, 0);

        // Reset mid-stream discards the partial sequence and restores defaults
        cfg(4'b1011, 1);
        send(1); send(0); send(1);
        reset_n = 0;
        tick();
        check("rst_mid_match", bus.match, 0);
        check("rst_mid_cnt", bus.match_cnt, 0);
        check("rst_mid_armed", bus.armed, 0);
        cfg(4'b1011, 1);
        send(1);
        check("rst_no_hit", bus.match, 0);
        send4(4'b1011);
        check("rst_rehit", bus.match, 1);

        // Runtime reconfig drops the bit offered on the load edge
        cfg(4'b1011, 1);
        pulses = 0;
        send(1); send(0); send(1);
        bus.cfg_load = 1; bus.pattern = 4'b0110; bus.overlap_en = 0;
        bus.in_valid = 1; bus.in = 1;
        tick();
        check("recfg_armed", bus.armed, 0);
        check("recfg_old_silent", bus.match, 0);
        send4(4'b0110);
        check("recfg_hit", bus.match, 1);
        check("recfg_pulses", pulses, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.in       = $urandom_range(0, 1);
            if ($urandom_range(0, 39) == 0) begin
                bus.cfg_load   = 1;
                bus.pattern    = 4'($urandom_range(0, 15));
                bus.overlap_en = $urandom_range(0, 1);
            end
            bus.clear_cnt = ($urandom_range(0, 29) == 0);
            reset_n       = !($urandom_range(0, 149) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
